z80_snd_mailbox: RTL and testbench

- Sound-command mailbox between the 68k and the Z80. It sequences the command and reply strobes decoded by the Z80 controller (nSDW, nSDZ80R, nSDZ80W, nSDZ80CLR).
- Latches the 68k command byte, generates and throttles the Z80 NMI, latches the Z80 reply for the 68k, and tracks pending/overrun status.
- Sits beside the Z80 address decoder and clock divider. All strobes are sampled in the CLK_24M domain.

---
 rtl/z80_snd_mailbox.sv | 229 ++++++++++++++++++++++
 tb/tb_z80_snd_mailbox.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_snd_mailbox.sv
// Sound-command mailbox between the 68k and the Z80: command latch, throttled NMI, reply path, status flags.
// Latency: strobe fall to register update SYNC_STAGES+1 cycles; NMI asserts one cycle after pending and enabled.
// No backpressure: overwrites set CMD_OVERRUN. Define SND_MBX_REPLY_FIFO_EN for a 4-entry reply FIFO.

`ifdef SND_MBX_REPLY_FIFO_EN
module snd_mbx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         core_clk,
  input  logic         arst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign out_vld = (count != '0);
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign in_rdy  = (count != (AW+1)'(DEPTH)) || out_rdy;
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;
  assign out_dat = mem[rd_ptr];

  always_ff @(posedge core_clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule
`endif

module z80_snd_mailbox #(
  parameter int SYNC_STAGES = 2,
  parameter int NMI_TIMEOUT = 4096,
  parameter int NMI_GAP     = 24
) (
  input  logic       CLK_24M,
  input  logic       nRESET,
  input  logic       nSDW,
  input  logic [7:0] M68K_DATA,
  input  logic       nREPLY_RD,
  input  logic       nSDZ80R,
  input  logic       nSDZ80W,
  input  logic       nSDZ80CLR,
  input  logic       nNMI_EN_WR,
  input  logic       nNMI_DIS_WR,
  input  logic [7:0] SDD_IN,
  output logic [7:0] SDD_CMD,
  output logic [7:0] M68K_REPLY,
  output logic       nZ80NMI,
  output logic       CMD_PENDING,
  output logic       REPLY_VALID,
  output logic       CMD_OVERRUN
);
  localparam int NSTB    = 7;
  localparam int CNT_MAX = (NMI_TIMEOUT > NMI_GAP) ? NMI_TIMEOUT : NMI_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((NMI_TIMEOUT > 0) ? NMI_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((NMI_GAP > 0) ? NMI_GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} nmi_state_t;

  logic [NSTB-1:0]                  strb_raw;
  logic [SYNC_STAGES:0][NSTB-1:0]   strb_pipe;
  logic [NSTB-1:0]                  ev;
  logic ev_cmd_wr, ev_rep_rd, ev_cmd_rd, ev_rep_wr, ev_clr, ev_nmi_en, ev_nmi_dis;

  logic [7:0]       cmd_q;
  logic             cmd_pend_q;
  logic             ovr_q;
  logic             nmi_en_q;
  logic             reply_drop;
  nmi_state_t       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  assign strb_raw = {nNMI_DIS_WR, nNMI_EN_WR, nSDZ80CLR, nSDZ80W, nSDZ80R, nREPLY_RD, nSDW};

  // Top stage holds the previous synchronized level, giving a one-cycle pulse per falling edge.
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) strb_pipe <= '1;
    else         strb_pipe <= {strb_pipe[SYNC_STAGES-1:0], strb_raw};
  end

  assign ev         = strb_pipe[SYNC_STAGES] & ~strb_pipe[SYNC_STAGES-1];
  assign ev_cmd_wr  = ev[0];
  assign ev_rep_rd  = ev[1];
  assign ev_cmd_rd  = ev[2];
  assign ev_rep_wr  = ev[3];
  assign ev_clr     = ev[4];
  assign ev_nmi_en  = ev[5];
  assign ev_nmi_dis = ev[6];

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      cmd_q      <= 8'h00;
      cmd_pend_q <= 1'b0;
      ovr_q      <= 1'b0;
      nmi_en_q   <= 1'b0;
    end else begin
      if (ev_clr) begin
        cmd_q      <= 8'h00;
        cmd_pend_q <= 1'b0;
      end else if (ev_cmd_wr) begin
        cmd_q      <= M68K_DATA;
        cmd_pend_q <= 1'b1;
      end else if (ev_cmd_rd) begin
        cmd_pend_q <= 1'b0;
      end

      // A write racing a read counts as consumed, not overwritten.
      if (ev_clr)
        ovr_q <= 1'b0;
      else if ((ev_cmd_wr && cmd_pend_q && !ev_cmd_rd) || reply_drop)
        ovr_q <= 1'b1;

      if (ev_nmi_dis)     nmi_en_q <= 1'b0;
      else if (ev_nmi_en) nmi_en_q <= 1'b1;
    end
  end

`ifdef SND_MBX_REPLY_FIFO_EN
  logic       rep_in_rdy;
  logic       rep_out_vld;
  logic [7:0] rep_out_dat;

  snd_mbx_fifo #(.W(8), .DEPTH(4)) u_reply_fifo (
    .core_clk (CLK_24M),
    .arst_n   (nRESET),
    .in_vld   (ev_rep_wr),
    .in_dat   (SDD_IN),
    .in_rdy   (rep_in_rdy),
    .out_vld  (rep_out_vld),
    .out_dat  (rep_out_dat),
    .out_rdy  (ev_rep_rd)
  );

  assign reply_drop  = ev_rep_wr && !rep_in_rdy;
  assign M68K_REPLY  = rep_out_vld ? rep_out_dat : 8'h00;
  assign REPLY_VALID = rep_out_vld;
`else
  logic [7:0] reply_q;
  logic       reply_vld_q;

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      reply_q     <= 8'h00;
      reply_vld_q <= 1'b0;
    end else if (ev_rep_wr) begin
      reply_q     <= SDD_IN;
      reply_vld_q <= 1'b1;
    end else if (ev_rep_rd) begin
      reply_vld_q <= 1'b0;
    end
  end

  assign reply_drop  = 1'b0;
  assign M68K_REPLY  = reply_q;
  assign REPLY_VALID = reply_vld_q;
`endif

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // cnt_q counts cycles spent in ACTIVE (timeout) or GAP (holdoff); cleared on every state change.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q + CNT_W'(1);
    unique case (state_q)
      IDLE: begin
        cnt_nxt = '0;
        if (cmd_pend_q && nmi_en_q) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (ev_cmd_rd || ev_clr || ev_nmi_dis || (NMI_TIMEOUT != 0 && cnt_q == TMO_LAST)) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end
      end
      GAP: begin
        // Leaving the holdoff with work pending re-fires directly so the gap is exactly NMI_GAP.
        if (cnt_q == GAP_LAST) begin
          state_nxt = (cmd_pend_q && nmi_en_q) ? ACTIVE : IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign nZ80NMI     = (state_q != ACTIVE);
  assign SDD_CMD     = cmd_q;
  assign CMD_PENDING = cmd_pend_q;
  assign CMD_OVERRUN = ovr_q;
endmodule

// File: tb/tb_z80_snd_mailbox.sv
// Bench for z80_snd_mailbox: directed and random strobe traffic against a rule-level reference model,
// with a per-cycle expected-output queue drained by an independent monitor.
module tb_z80_snd_mailbox;
  localparam int SYNC = 2;
  localparam int TMO  = 16;
  localparam int GAP  = 24;
  localparam logic [6:0] M_WR  = 7'h01;
  localparam logic [6:0] M_RRD = 7'h02;
  localparam logic [6:0] M_ZRD = 7'h04;
  localparam logic [6:0] M_ZWR = 7'h08;
  localparam logic [6:0] M_CLR = 7'h10;
  localparam logic [6:0] M_EN  = 7'h20;
  localparam logic [6:0] M_DIS = 7'h40;

  logic       CLK_24M = 1'b0;
  logic       nRESET  = 1'b0;
  logic [6:0] strb    = '1;
  logic [7:0] M68K_DATA = 8'h00;
  logic [7:0] SDD_IN    = 8'h00;
  logic [7:0] SDD_CMD, M68K_REPLY;
  logic       nZ80NMI, CMD_PENDING, REPLY_VALID, CMD_OVERRUN;

  always #5 CLK_24M = ~CLK_24M;

  z80_snd_mailbox #(.SYNC_STAGES(SYNC), .NMI_TIMEOUT(TMO), .NMI_GAP(GAP)) dut (
    .CLK_24M     (CLK_24M),
    .nRESET      (nRESET),
    .nSDW        (strb[0]),
    .M68K_DATA   (M68K_DATA),
    .nREPLY_RD   (strb[1]),
    .nSDZ80R     (strb[2]),
    .nSDZ80W     (strb[3]),
    .nSDZ80CLR   (strb[4]),
    .nNMI_EN_WR  (strb[5]),
    .nNMI_DIS_WR (strb[6]),
    .SDD_IN      (SDD_IN),
    .SDD_CMD     (SDD_CMD),
    .M68K_REPLY  (M68K_REPLY),
    .nZ80NMI     (nZ80NMI),
    .CMD_PENDING (CMD_PENDING),
    .REPLY_VALID (REPLY_VALID),
    .CMD_OVERRUN (CMD_OVERRUN)
  );

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] reply;
    logic       nmi_n;
    logic       pend;
    logic       valid;
    logic       ovr;
  } snap_t;

  snap_t      exp_q[$];
  logic [6:0] ev_tab [int];
  int         cyc   = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  // Reference model state: mailbox contents plus how long the NMI line has been low / high.
  logic [7:0] m_cmd, m_reply;
  logic [7:0] m_rq[$];
  bit         m_pend, m_ovr, m_en, m_valid, m_low;
  int         low_run, high_run;

  function automatic void m_reset();
    m_cmd = 8'h00; m_reply = 8'h00; m_rq.delete();
    m_pend = 0; m_ovr = 0; m_en = 0; m_valid = 0; m_low = 0;
    low_run = 0; high_run = 1 << 30;
  endfunction

  function automatic snap_t mk_snap();
    snap_t s;
    s.cmd   = m_cmd;
`ifdef SND_MBX_REPLY_FIFO_EN
    s.reply = (m_rq.size() > 0) ? m_rq[0] : 8'h00;
    s.valid = (m_rq.size() > 0);
`else
    s.reply = m_reply;
    s.valid = m_valid;
`endif
    s.nmi_n = !m_low;
    s.pend  = m_pend;
    s.ovr   = m_ovr;
    return s;
  endfunction

  always @(posedge CLK_24M) begin
    logic [6:0] e;
    logic [7:0] dmy;
    bit wr, rr, zr, zw, cl, en, di, nxt_low, drop;
    if (!nRESET) begin
      m_reset();
    end else begin
      e = ev_tab.exists(cyc) ? ev_tab[cyc] : 7'h00;
      if (ev_tab.exists(cyc)) ev_tab.delete(cyc);
      wr = e[0]; rr = e[1]; zr = e[2]; zw = e[3]; cl = e[4]; en = e[5]; di = e[6];

      if (m_low) nxt_low = !(zr || cl || di) && !(TMO != 0 && low_run >= TMO);
      else       nxt_low = m_pend && m_en && (high_run >= GAP);
      if (nxt_low) low_run = m_low ? low_run + 1 : 1;
      else         high_run = m_low ? 1 : ((high_run < (1 << 30)) ? high_run + 1 : high_run);
      m_low = nxt_low;

      drop = 0;
`ifdef SND_MBX_REPLY_FIFO_EN
      if (rr && m_rq.size() > 0) dmy = m_rq.pop_front();
      if (zw) begin
        if (m_rq.size() < 4) m_rq.push_back(SDD_IN);
        else drop = 1;
      end
`else
      if (zw) begin m_reply = SDD_IN; m_valid = 1; end
      else if (rr) m_valid = 0;
`endif
      if (cl) begin
        m_cmd = 8'h00; m_pend = 0; m_ovr = 0;
      end else begin
        if ((wr && m_pend && !zr) || drop) m_ovr = 1;
        if (wr) begin m_cmd = M68K_DATA; m_pend = 1; end
        else if (zr) m_pend = 0;
      end
      if (di) m_en = 0;
      else if (en) m_en = 1;
    end
    cyc = cyc + 1;
    exp_q.push_back(mk_snap());
  end

  always @(negedge CLK_24M) begin
    snap_t x, a;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      a = {SDD_CMD, M68K_REPLY, nZ80NMI, CMD_PENDING, REPLY_VALID, CMD_OVERRUN};
      n_cmp++;
      if (a !== x) begin
        n_bad++;
        $display("FAIL outputs@cyc%0d: got cmd=%h rep=%h nmi_n=%b pend=%b vld=%b ovr=%b, want cmd=%h rep=%h nmi_n=%b pend=%b vld=%b ovr=%b",
                 cyc, a.cmd, a.reply, a.nmi_n, a.pend, a.valid, a.ovr,
                 x.cmd, x.reply, x.nmi_n, x.pend, x.valid, x.ovr);
      end
    end
  end

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge CLK_24M);
      #1;
    end
  endtask

  // Drop the masked strobes together; the model sees the resulting events SYNC cycles later.
  task automatic pulse(input logic [6:0] mask, input int width);
    logic [6:0] prev;
    prev = ev_tab.exists(cyc + SYNC) ? ev_tab[cyc + SYNC] : 7'h00;
    ev_tab[cyc + SYNC] = prev | mask;
    strb = strb & ~mask;
    tick(width);
    strb = '1;
    tick(1);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    logic [6:0] pick [13];
    logic [6:0] m;
    int guard;
    pick = '{M_WR, M_WR, M_WR, M_ZRD, M_ZRD, M_CLR, M_EN, M_EN, M_DIS, M_ZWR, M_ZWR, M_RRD, M_RRD};

    tick(3);
    nRESET = 1'b1;
    tick(2);

    // Basic command + NMI handshake
    pulse(M_EN, 1);
    M68K_DATA = 8'h5A; pulse(M_WR, 2);
    tick(8);
    pulse(M_ZRD, 2);
    tick(30);

    // Deferred NMI while disabled
    pulse(M_DIS, 1);
    M68K_DATA = 8'h13; pulse(M_WR, 1);
    tick(100);
    pulse(M_EN, 1);
    tick(6);
    pulse(M_ZRD, 1);
    tick(30);

    // Overrun then clear
    M68K_DATA = 8'h01; pulse(M_WR, 1);
    M68K_DATA = 8'h02; pulse(M_WR, 1);
    tick(5);
    pulse(M_CLR, 1);
    tick(30);

    // Timeout and re-fire after the gap
    M68K_DATA = 8'h07; pulse(M_WR, 1);
    tick(100);
    pulse(M_ZRD, 1);
    tick(30);

    // Reply path, then five pushes / five pops
    SDD_IN = 8'hA5; pulse(M_ZWR, 1);
    tick(5);
    pulse(M_RRD, 1);
    tick(5);
    for (int i = 1; i <= 5; i++) begin
      SDD_IN = 8'(i); pulse(M_ZWR, 1);
    end
    tick(5);
    for (int i = 0; i < 5; i++) pulse(M_RRD, 2);
    tick(5);

    // Same-cycle event pairs
    M68K_DATA = 8'h11; pulse(M_WR, 1);
    M68K_DATA = 8'h22; pulse(M_WR | M_ZRD, 2);
    tick(5);
    M68K_DATA = 8'h33; pulse(M_WR | M_CLR, 1);
    SDD_IN = 8'h44; pulse(M_ZWR | M_RRD, 1);
    pulse(M_EN | M_DIS, 1);
    tick(10);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      M68K_DATA = 8'($urandom);
      SDD_IN    = 8'($urandom);
      m = pick[$urandom_range(12, 0)];
      if ($urandom_range(3, 0) == 0) m = m | pick[$urandom_range(12, 0)];
      pulse(m, $urandom_range(4, 1));
      tick($urandom_range(40, 0));
    end

    // Asynchronous reset while the NMI is asserted
    SDD_IN = 8'hC3; pulse(M_ZWR, 1);
    pulse(M_CLR, 1);
    tick(GAP + 4);
    pulse(M_EN, 1);
    M68K_DATA = 8'h3C; pulse(M_WR, 1);
    guard = 0;
    while (!m_low && guard < 50) begin
      tick(1);
      guard++;
    end
    check("nmi_before_reset", {7'h0, nZ80NMI}, 8'h00);
    #2;
    nRESET = 1'b0;
    exp_q.delete();
    ev_tab.delete();
    #1;
    check("rst_nmi_n",   {7'h0, nZ80NMI},     8'h01);
    check("rst_sdd_cmd", SDD_CMD,             8'h00);
    check("rst_reply",   M68K_REPLY,          8'h00);
    check("rst_pending", {7'h0, CMD_PENDING}, 8'h00);
    check("rst_valid",   {7'h0, REPLY_VALID}, 8'h00);
    check("rst_overrun", {7'h0, CMD_OVERRUN}, 8'h00);
    tick(3);
    nRESET = 1'b1;
    tick(20);
    @(negedge CLK_24M);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
